seq_shift_add_mult: RTL and testbench

Iterative shift-add multiplier generalising the team's fixed 4x4 partial-product multiplier. Width is parametrised, there is a signed/unsigned mode, and valid/ready handshakes sit on both sides. One partial product is accumulated per clock, trading latency for area. It sits behind arithmetic-rewrite benches as a sequential equivalence target and as a low-area multiply unit.

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/seq_mult_step.sv | 14 +
 rtl/seq_shift_add_mult.sv | 81 ++++++++
 tb/tb_seq_shift_add_mult.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared states and helpers for the shift-add multiplier
package seq_mult_pkg;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
  // magnitude of a w-bit value carried in a MAX_W container; -2^(w-1) maps to 2^(w-1)
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value, input int w, input logic is_signed);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : (MAX_W'(1) << w) - MAX_W'(1);
    return (is_signed && value[w-1]) ? (~value + MAX_W'(1)) & mask : value & mask;
  endfunction
endpackage

// File: rtl/seq_mult_step.sv
// seq_mult_step: one shift-add iteration (next accumulator and multiplier)
module seq_mult_step import seq_mult_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0]            acc_i,
  input  logic [WIDTH-1:0]              mcand_i,
  input  logic [WIDTH-1:0]              mplier_i,
  input  logic [cnt_width(WIDTH)-1:0]   cnt_i,
  output logic [2*WIDTH-1:0]            acc_o,
  output logic [WIDTH-1:0]              mplier_o
);
  assign acc_o = mplier_i[0] ? acc_i + ({{WIDTH{1'b0}}, mcand_i} << cnt_i) : acc_i;
  assign mplier_o = mplier_i >> 1;
endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: iterative shift-add multiplier, one partial product per clock
module seq_shift_add_mult import seq_mult_pkg::*; #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = cnt_width(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, mplier_nx;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx, product_q, product_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, sm;
  seq_mult_step #(.WIDTH(WIDTH)) u_step (
    .acc_i(acc_q), .mcand_i(mcand_q), .mplier_i(mplier_q), .cnt_i(cnt_q),
    .acc_o(acc_nx), .mplier_o(mplier_nx)
  );
  assign sm = signed_mode & SIGNED_EN;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign product = product_q;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        mcand_d = WIDTH'(abs_mag(MAX_W'(a), WIDTH, sm));
        mplier_d = WIDTH'(abs_mag(MAX_W'(b), WIDTH, sm));
        neg_d = sm & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_d = '0;
        cnt_d = '0;
      end
      BUSY: begin
        acc_d = acc_nx;
        mplier_d = mplier_nx;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : BUSY;
      end
      FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: table vectors, corner sequences and random sweep against an arithmetic model
module tb_seq_shift_add_mult;
  logic clk = 0, rst = 1, sm = 0;
  logic [7:0] ta = 0, tb_ = 0;
  logic [2:0] iv = 0, ordy = 0;
  wire [2:0] ir, ov;
  wire [7:0] p0, p1;
  wire [15:0] p2;
  int n_cmp = 0, n_fail = 0;
  int hs[3] = '{0, 0, 0};
  int ops[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(4), .SIGNED_EN(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[3:0]), .b(tb_[3:0]),
    .signed_mode(sm), .out_valid(ov[0]), .out_ready(ordy[0]), .product(p0));
  seq_shift_add_mult #(.WIDTH(4), .SIGNED_EN(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[3:0]), .b(tb_[3:0]),
    .signed_mode(sm), .out_valid(ov[1]), .out_ready(ordy[1]), .product(p1));
  seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta), .b(tb_),
    .signed_mode(sm), .out_valid(ov[2]), .out_ready(ordy[2]), .product(p2));

  always @(posedge clk)
    for (int k = 0; k < 3; k++) if (!rst && ov[k] && ordy[k]) hs[k]++;

  function automatic logic [15:0] prod(input int k);
    return k == 0 ? {8'h0, p0} : k == 1 ? {8'h0, p1} : p2;
  endfunction

  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] x, input logic [7:0] y, input logic s);
    longint va, vb, m;
    va = longint'(x) & ((longint'(1) << w) - 1);
    vb = longint'(y) & ((longint'(1) << w) - 1);
    if (s && x[w-1]) va -= longint'(1) << w;
    if (s && y[w-1]) vb -= longint'(1) << w;
    m = (va * vb) & ((longint'(1) << (2 * w)) - 1);
    return 16'(m);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y, input logic s,
                        input int stall, input logic [15:0] exp);
    int w, lat;
    logic [15:0] p;
    w = (k == 2) ? 8 : 4;
    @(negedge clk);
    ta = x; tb_ = y; sm = s; iv[k] = 1;
    lat = 0;
    while (!ir[k] && lat < 50) begin @(negedge clk); lat++; end
    @(posedge clk); #1;
    ops[k]++;
    iv[k] = 0; ta = 8'($urandom); tb_ = 8'($urandom); sm = 1'($urandom);
    lat = 0;
    while (!ov[k] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("latency", 16'(lat), 16'(w + 1));
    p = prod(k);
    chk("product", p, exp);
    for (int i = 0; i < stall; i++) begin iv[k] = 1; @(posedge clk); #1; end
    iv[k] = 0;
    if (stall > 0) begin
      chk("hold_valid", 16'(ov[k]), 16'd1);
      chk("hold_product", prod(k), exp);
      chk("busy_ready", 16'(ir[k]), 16'd0);
    end
    ordy[k] = 1; @(posedge clk); #1; ordy[k] = 0;
    chk("post_valid", 16'(ov[k]), 16'd0);
    chk("post_ready", 16'(ir[k]), 16'd1);
    chk("post_product", prod(k), exp);
  endtask

  typedef struct {
    int k;
    logic [7:0] a, b;
    logic s;
    int stall;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t vt[10];
    vt[0] = '{0, 8'd15, 8'd15, 1'b0, 3, 16'h00E1};
    vt[1] = '{0, 8'h8, 8'h8, 1'b1, 0, 16'h0040};
    vt[2] = '{0, 8'h8, 8'h7, 1'b1, 0, 16'h00C8};
    vt[3] = '{0, 8'h0, 8'hD, 1'b1, 1, 16'h0000};
    vt[4] = '{0, 8'hF, 8'h1, 1'b1, 0, 16'h00FF};
    vt[5] = '{1, 8'hF, 8'h1, 1'b1, 0, 16'h000F};
    vt[6] = '{2, 8'h80, 8'h80, 1'b1, 2, 16'h4000};
    vt[7] = '{2, 8'hFF, 8'hFF, 1'b0, 0, 16'hFE01};
    vt[8] = '{2, 8'h80, 8'h7F, 1'b1, 0, 16'hC080};
    vt[9] = '{0, 8'hF, 8'hF, 1'b0, 10, 16'h00E1};
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 16'(ir[k]), 16'd1);
      chk("reset_valid", 16'(ov[k]), 16'd0);
      chk("reset_product", prod(k), 16'd0);
    end
    rst = 0;
    foreach (vt[i]) run_op(vt[i].k, vt[i].a, vt[i].b, vt[i].s, vt[i].stall, vt[i].exp);
    // abort an in-flight operation with reset during its second busy cycle
    @(negedge clk);
    ta = 8'hF; tb_ = 8'hF; sm = 0; iv[0] = 1;
    @(posedge clk); #1;
    iv[0] = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_ready", 16'(ir[0]), 16'd1);
    chk("rst_mid_valid", 16'(ov[0]), 16'd0);
    chk("rst_mid_product", prod(0), 16'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_ghost", 16'(ov[0]), 16'd0);
    run_op(0, 8'd3, 8'd5, 1'b0, 0, 16'd15);
    for (int i = 0; i < 512; i++) begin
      logic [7:0] x, y;
      logic s;
      x = 8'(i & 15); y = 8'((i >> 4) & 15); s = 1'(i >> 8);
      run_op(0, x, y, s, $urandom_range(0, 2), ref_mul(4, x, y, s));
    end
    for (int i = 0; i < 32; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom_range(0, 15)); y = 8'($urandom_range(0, 15));
      run_op(1, x, y, 1'($urandom), $urandom_range(0, 1), ref_mul(4, x, y, 1'b0));
    end
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] x, y;
      logic s;
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
      run_op(2, x, y, s, $urandom_range(0, 3), ref_mul(8, x, y, s));
    end
    for (int k = 0; k < 3; k++) chk("handshake_count", 16'(hs[k]), 16'(ops[k]));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
